// File: rtl/axis_header_arbiter.sv
// axis_header_arbiter: locks one of NUM_CH header+payload sources onto a header inserter until its last beat.
// Round-robin by default; define HDR_ARB_FIXED_PRIO_EN for lowest-index-wins priority without a pointer.
module axis_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int NUM_CH       = 4,
    parameter int CH_WD        = $clog2(NUM_CH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CH-1:0]                s_hdr_valid,
    input  logic [NUM_CH*DATA_WD-1:0]        s_hdr_data,
    input  logic [NUM_CH*DATA_BYTE_WD-1:0]   s_hdr_keep,
    output logic [NUM_CH-1:0]                s_hdr_ready,
    input  logic [NUM_CH-1:0]                s_valid,
    input  logic [NUM_CH*DATA_WD-1:0]        s_data,
    input  logic [NUM_CH*DATA_BYTE_WD-1:0]   s_keep,
    input  logic [NUM_CH-1:0]                s_last,
    output logic [NUM_CH-1:0]                s_ready,
    output logic                             m_hdr_valid,
    output logic [DATA_WD-1:0]               m_hdr_data,
    output logic [DATA_BYTE_WD-1:0]          m_hdr_keep,
    input  logic                             m_hdr_ready,
    output logic                             m_valid,
    output logic [DATA_WD-1:0]               m_data,
    output logic [DATA_BYTE_WD-1:0]          m_keep,
    output logic                             m_last,
    input  logic                             m_ready,
    output logic [CH_WD-1:0]                 grant_id,
    output logic                             busy
);
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CH_WD-1:0]  r_grant;
    logic [CH_WD-1:0]  w_win;
    logic              w_hdr_fire;
    logic              w_pay_done;

    assign w_hdr_fire = (r_state == HDR) && m_hdr_valid && m_hdr_ready;
    assign w_pay_done = (r_state == PAY) && m_valid && m_ready && m_last;
    assign grant_id   = r_grant;
    assign busy       = (r_state != IDLE);

`ifdef HDR_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (s_hdr_valid[i]) w_win = CH_WD'(i);
    end
`else
    logic [CH_WD-1:0] r_rr_ptr;

    // Scanning downward leaves the first requester at or after r_rr_ptr as the winner.
    always_comb begin
        w_win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (s_hdr_valid[(int'(r_rr_ptr) + i) % NUM_CH])
                w_win = CH_WD'((int'(r_rr_ptr) + i) % NUM_CH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rr_ptr <= '0;
        else if (w_pay_done)
            r_rr_ptr <= (r_grant == CH_WD'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |s_hdr_valid) r_grant <= w_win;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = |s_hdr_valid ? HDR : IDLE;
            HDR:     w_next = w_hdr_fire ? PAY : HDR;
            PAY:     w_next = w_pay_done ? IDLE : PAY;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        m_hdr_valid = 1'b0;
        m_hdr_data  = '0;
        m_hdr_keep  = '0;
        s_hdr_ready = '0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_keep      = '0;
        m_last      = 1'b0;
        s_ready     = '0;
        if (r_state == HDR) begin
            m_hdr_valid          = s_hdr_valid[r_grant];
            m_hdr_data           = s_hdr_data[r_grant*DATA_WD +: DATA_WD];
            m_hdr_keep           = s_hdr_keep[r_grant*DATA_BYTE_WD +: DATA_BYTE_WD];
            s_hdr_ready[r_grant] = m_hdr_ready;
        end
        if (r_state == PAY) begin
            m_valid          = s_valid[r_grant];
            m_data           = s_data[r_grant*DATA_WD +: DATA_WD];
            m_keep           = s_keep[r_grant*DATA_BYTE_WD +: DATA_BYTE_WD];
            m_last           = s_last[r_grant];
            s_ready[r_grant] = m_ready;
        end
    end
endmodule

// File: tb/tb_axis_header_arbiter.sv
// tb_axis_header_arbiter: per-test expected grant order is queued up front; headers and beats are
// checked against bench-generated values as the DUT hands them to the inserter side.
`timescale 1ns/1ps
module tb_axis_header_arbiter;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int N  = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    s_hdr_valid, s_hdr_ready, s_valid, s_last, s_ready;
    logic [N*DW-1:0] s_hdr_data, s_data;
    logic [N*KW-1:0] s_hdr_keep, s_keep;
    logic            m_hdr_valid, m_hdr_ready, m_valid, m_last, m_ready, busy;
    logic [DW-1:0]   m_hdr_data, m_data;
    logic [KW-1:0]   m_hdr_keep, m_keep;
    logic [CW-1:0]   grant_id;

    int checks = 0;
    int failures = 0;

    int            src_rem[N], src_seq[N], src_beat[N], nbeats[N], mseq[N];
    bit            src_pay[N];
    logic [DW-1:0] hdr_base[N];
    logic [KW-1:0] hdr_keep[N];
    logic [N-1:0]  fh, fp;
    bit            tog, mon_en, in_pay, gap;
    int            exp_q[$];
    int            cur_ch, mbeat;

    always #5 clk = ~clk;

    axis_header_arbiter #(.DATA_WD(DW), .NUM_CH(N)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_hdr_valid(s_hdr_valid), .s_hdr_data(s_hdr_data), .s_hdr_keep(s_hdr_keep), .s_hdr_ready(s_hdr_ready),
        .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_ready(s_ready),
        .m_hdr_valid(m_hdr_valid), .m_hdr_data(m_hdr_data), .m_hdr_keep(m_hdr_keep), .m_hdr_ready(m_hdr_ready),
        .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_ready(m_ready),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pay_word(input int ch, input int seq, input int beat);
        return 32'h5A00_0000 ^ {8'(ch), 8'(seq), 16'(beat)};
    endfunction

    function automatic logic [KW-1:0] beat_keep(input bit last);
        return last ? 4'h7 : 4'hF;
    endfunction

    function automatic bit src_idle();
        for (int c = 0; c < N; c++)
            if (src_rem[c] != 0 || src_pay[c]) return 1'b0;
        return 1'b1;
    endfunction

    // Source models: present a header while packets remain, then stream nbeats payload beats.
    initial forever begin
        @(negedge clk);
        fh = s_hdr_valid & s_hdr_ready;
        fp = s_valid & s_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (fh[c]) begin
                src_pay[c]  = 1'b1;
                src_beat[c] = 0;
            end else if (fp[c]) begin
                if (src_beat[c] == nbeats[c] - 1) begin
                    src_pay[c] = 1'b0;
                    src_seq[c]++;
                    src_rem[c]--;
                end else src_beat[c]++;
            end
            s_hdr_valid[c]         = !src_pay[c] && src_rem[c] > 0;
            s_hdr_data[c*DW +: DW] = hdr_base[c] + DW'(src_seq[c]);
            s_hdr_keep[c*KW +: KW] = hdr_keep[c];
            s_valid[c]             = src_pay[c];
            s_last[c]              = (src_beat[c] == nbeats[c] - 1);
            s_data[c*DW +: DW]     = pay_word(c, src_seq[c], src_beat[c]);
            s_keep[c*KW +: KW]     = beat_keep(src_beat[c] == nbeats[c] - 1);
        end
        if (tog) m_ready = !m_ready;
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (gap) chk("idle_gap", busy, 0);
            gap = 1'b0;
            if (!busy) begin
                chk("idle_phase", in_pay, 0);
                chk("idle_ctl", {m_hdr_valid, m_valid, m_last, s_hdr_ready, s_ready, m_hdr_keep, m_keep}, 0);
                chk("idle_dat", {m_hdr_data, m_data}, 0);
            end else if (!in_pay) begin
                if (exp_q.size() == 0) chk("unexp_grant", busy, 0);
                else begin
                    chk("hdr_rdy", s_hdr_ready, 64'(m_hdr_ready) << exp_q[0]);
                    chk("hdr_quiet", {m_valid, s_ready, m_data}, 0);
                    if (m_hdr_valid && m_hdr_ready) begin
                        cur_ch = exp_q.pop_front();
                        chk("grant", grant_id, cur_ch);
                        chk("hdr_data", m_hdr_data, hdr_base[cur_ch] + DW'(mseq[cur_ch]));
                        chk("hdr_keep", m_hdr_keep, hdr_keep[cur_ch]);
                        in_pay = 1'b1;
                        mbeat  = 0;
                    end
                end
            end else begin
                chk("pay_rdy", s_ready, 64'(m_ready) << cur_ch);
                chk("pay_quiet", {m_hdr_valid, s_hdr_ready, m_hdr_data}, 0);
                if (m_valid && m_ready) begin
                    chk("beat_data", m_data, pay_word(cur_ch, mseq[cur_ch], mbeat));
                    chk("beat_last", m_last, mbeat == nbeats[cur_ch] - 1);
                    chk("beat_keep", m_keep, beat_keep(mbeat == nbeats[cur_ch] - 1));
                    if (mbeat == nbeats[cur_ch] - 1) begin
                        in_pay = 1'b0;
                        gap    = 1'b1;
                        mseq[cur_ch]++;
                    end else mbeat++;
                end
            end
        end
    end

    task automatic wait_done(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            done = exp_q.size() == 0 && !in_pay && !busy && src_idle();
        end
        chk(tag, done, 1);
    endtask

    task automatic push_order(input int a, input int b, input int c, input int d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    initial begin
        rst_n = 1'b0;
        s_hdr_valid = '0; s_hdr_data = '0; s_hdr_keep = '0;
        s_valid = '0; s_data = '0; s_keep = '0; s_last = '0;
        m_hdr_ready = 1'b1; m_ready = 1'b1;
        tog = 1'b0; mon_en = 1'b0;
        for (int c = 0; c < N; c++) begin
            nbeats[c]   = 1;
            hdr_base[c] = 32'h1000_0000 * (c + 1);
            hdr_keep[c] = 4'hF;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ctl", {busy, m_hdr_valid, m_valid, s_hdr_ready, s_ready, grant_id}, 0);
        chk("rst_dat", {m_hdr_data, m_data}, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;

        // Single channel 0, three beats, header one cycle after request.
        hdr_base[0] = 32'hA1B2_C3D4;
        hdr_keep[0] = 4'b0011;
        nbeats[0]   = 3;
        exp_q.push_back(0);
        src_rem[0]  = 1;
        @(posedge clk);
        @(negedge clk);
        chk("lat_idle", busy, 0);
        @(negedge clk);
        chk("lat_hdr", {m_hdr_valid, m_hdr_data, m_hdr_keep}, {1'b1, 32'hA1B2_C3D4, 4'b0011});
        wait_done("done_single", 50);

        // Inserter stalls the header; the FSM must hold in HDR on channel 2.
        m_hdr_ready = 1'b0;
        exp_q.push_back(2);
        src_rem[2] = 1;
        repeat (4) @(negedge clk);
        chk("stall_hdr", {busy, m_hdr_valid, s_hdr_ready, grant_id}, {1'b1, 1'b1, 4'b0000, 2'd2});
        @(posedge clk);
        #1 m_hdr_ready = 1'b1;
        wait_done("done_stall", 50);

        // Pointer sits at 3; only channel 0 requests, selection wraps.
        nbeats[0] = 2;
        exp_q.push_back(0);
        src_rem[0] = 1;
        wait_done("done_wrap", 50);

        // Four beats on channel 3 with m_ready toggling every cycle.
        nbeats[3] = 4;
        exp_q.push_back(3);
        src_rem[3] = 1;
        tog = 1'b1;
        wait_done("done_toggle", 80);
        tog = 1'b0;
        m_ready = 1'b1;

        // Channels 0 and 2 requesting continuously with single-beat packets.
        nbeats[0] = 1;
        nbeats[2] = 1;
`ifdef HDR_ARB_FIXED_PRIO_EN
        push_order(0, 0, 2, 2);
`else
        push_order(0, 2, 0, 2);
`endif
        src_rem[0] = 2;
        src_rem[2] = 2;
        wait_done("done_rr02", 80);

        // Reset mid-payload of channel 1, then channels 2 and 3 arbitrate from a cleared pointer.
        nbeats[1] = 6;
        exp_q.push_back(1);
        src_rem[1] = 1;
        for (int i = 0; i < 40 && !(in_pay && mbeat >= 2); i++) @(negedge clk);
        chk("pay_reached", in_pay && mbeat >= 2, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ctl", {busy, m_hdr_valid, m_valid, m_last, s_hdr_ready, s_ready, grant_id}, 0);
        chk("arst_dat", {m_data, m_hdr_data}, 0);
        mon_en = 1'b0;
        exp_q.delete();
        in_pay = 1'b0;
        gap    = 1'b0;
        src_pay[1] = 1'b0; src_beat[1] = 0; src_rem[1] = 0;
        nbeats[2] = 2;
        nbeats[3] = 2;
        exp_q.push_back(2);
        exp_q.push_back(3);
        src_rem[2] = 1;
        src_rem[3] = 1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        mon_en = 1'b1;
        wait_done("done_post_rst", 80);

        // Channels 1 and 3 contending; fixed priority starves 3 while 1 requests.
        nbeats[1] = 1;
        nbeats[3] = 1;
`ifdef HDR_ARB_FIXED_PRIO_EN
        push_order(1, 1, 3, 3);
`else
        push_order(1, 3, 1, 3);
`endif
        src_rem[1] = 2;
        src_rem[3] = 2;
        wait_done("done_ch13", 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
